// File: rtl/rv_pipe_ctrl_if.sv
// rv_pipe_ctrl_if: decode/hazard control bus between the RV32I datapath and rv_pipe_ctrl.
// Datapath -> control: op_d, funct3_d, rs1_d, rs2_d, rd_d (D stage); zero_e, lt_e, ltu_e (E flags).
// Control -> datapath: imm_src_d, illegal_d, alu_src_e, alu_op_e, sel_adder_e, pc_src_e, mem_write_m,
//   reg_write_w, result_src_w, rd_e/rd_m/rd_w, stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e.
// master = datapath side, slave = control side.
interface rv_pipe_ctrl_if #(parameter int REG_ADDR_W = 5);
  logic [6:0]            op_d;
  logic [2:0]            funct3_d;
  logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rd_d;
  logic                  zero_e, lt_e, ltu_e;
  logic [2:0]            imm_src_d;
  logic                  illegal_d;
  logic                  alu_src_e;
  logic [1:0]            alu_op_e;
  logic                  sel_adder_e, pc_src_e, mem_write_m, reg_write_w;
  logic [1:0]            result_src_w;
  logic [REG_ADDR_W-1:0] rd_e, rd_m, rd_w;
  logic                  stall_f, stall_d, flush_d, flush_e;
  logic [1:0]            fwd_a_e, fwd_b_e;
  modport master (
    output op_d, funct3_d, rs1_d, rs2_d, rd_d, zero_e, lt_e, ltu_e,
    input  imm_src_d, illegal_d, alu_src_e, alu_op_e, sel_adder_e, pc_src_e, mem_write_m, reg_write_w,
           result_src_w, rd_e, rd_m, rd_w, stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e
  );
  modport slave (
    input  op_d, funct3_d, rs1_d, rs2_d, rd_d, zero_e, lt_e, ltu_e,
    output imm_src_d, illegal_d, alu_src_e, alu_op_e, sel_adder_e, pc_src_e, mem_write_m, reg_write_w,
           result_src_w, rd_e, rd_m, rd_w, stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e
  );
endinterface

// File: rtl/rv_pipe_ctrl.sv
// rv_pipe_ctrl: RV32I decode plus D->E->M->W control pipeline with branch resolve, stall, flush and forwarding.
// Ports: clk, rst (sync, active-high); io_bus (rv_pipe_ctrl_if.slave) carries all D inputs, E flags and controls.
// FWD_EN=1 bypasses from M/W and stalls only on load-use; FWD_EN=0 stalls while a RAW producer sits in E or M.
module rv_pipe_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1
) (
  input logic          clk,
  input logic          rst,
  rv_pipe_ctrl_if.slave io_bus
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011, OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
  typedef struct packed {
    logic                  rw;
    logic [1:0]            res;
    logic                  mw, br, jmp;
    logic [2:0]            f3;
    logic                  src;
    logic [1:0]            op;
    logic                  sel;
    logic [REG_ADDR_W-1:0] rd, rs1, rs2;
  } e_slot_t;
  typedef struct packed {
    logic                  rw;
    logic [1:0]            res;
    logic                  mw;
    logic [REG_ADDR_W-1:0] rd;
  } m_slot_t;
  e_slot_t               w_dec, r_e;
  m_slot_t               r_m;
  logic                  r_rw_w;
  logic [1:0]            r_res_w;
  logic [REG_ADDR_W-1:0] r_rd_w;
  logic [2:0]            w_imm;
  logic                  w_ill, w_use1, w_use2, w_taken, w_pc_src, w_hit_e, w_hit_m, w_haz, w_stall, w_flush_e;
  always_comb begin
    w_dec  = '0;
    w_imm  = 3'b000;
    w_ill  = 1'b0;
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    case (io_bus.op_d)
      OP_R:    begin w_dec.rw = 1'b1; w_dec.op = 2'b10; w_use1 = 1'b1; w_use2 = 1'b1; end
      OP_I:    begin w_dec.rw = 1'b1; w_dec.src = 1'b1; w_dec.op = 2'b10; w_use1 = 1'b1; end
      OP_LW:   begin w_dec.rw = 1'b1; w_dec.res = 2'b01; w_dec.src = 1'b1; w_use1 = 1'b1; end
      OP_S:    begin w_dec.mw = 1'b1; w_dec.src = 1'b1; w_imm = 3'b001; w_use1 = 1'b1; w_use2 = 1'b1; end
      OP_B:    begin w_dec.br = 1'b1; w_dec.op = 2'b01; w_imm = 3'b010; w_use1 = 1'b1; w_use2 = 1'b1; end
      OP_JAL:  begin w_dec.jmp = 1'b1; w_dec.rw = 1'b1; w_dec.res = 2'b10; w_imm = 3'b100; end
      OP_JALR: begin w_dec.jmp = 1'b1; w_dec.rw = 1'b1; w_dec.res = 2'b10; w_dec.src = 1'b1; w_dec.sel = 1'b1; w_use1 = 1'b1; end
      OP_LUI:  begin w_dec.rw = 1'b1; w_dec.src = 1'b1; w_dec.op = 2'b11; w_imm = 3'b011; end
      default: w_ill = 1'b1;
    endcase
    w_dec.f3  = io_bus.funct3_d;
    // Zeroing rd of non-writers and rs of unused sources lets every compare below skip separate enable terms.
    w_dec.rd  = w_dec.rw ? io_bus.rd_d : '0;
    w_dec.rs1 = w_use1 ? io_bus.rs1_d : '0;
    w_dec.rs2 = w_use2 ? io_bus.rs2_d : '0;
  end
  // funct3[2:1] picks the flag, funct3[0] inverts it; 010/011 are never taken.
  assign w_taken   = (r_e.f3[2:1] == 2'b00) ? io_bus.zero_e ^ r_e.f3[0] :
                     (r_e.f3[2:1] == 2'b10) ? io_bus.lt_e ^ r_e.f3[0] :
                     (r_e.f3[2:1] == 2'b11) ? io_bus.ltu_e ^ r_e.f3[0] : 1'b0;
  assign w_pc_src  = !rst & (r_e.jmp | (r_e.br & w_taken));
  assign w_hit_e   = (r_e.rd != '0) & ((w_dec.rs1 == r_e.rd) | (w_dec.rs2 == r_e.rd));
  assign w_hit_m   = (r_m.rd != '0) & ((w_dec.rs1 == r_m.rd) | (w_dec.rs2 == r_m.rd));
  assign w_haz     = FWD_EN ? (r_e.res == 2'b01) & w_hit_e : w_hit_e | w_hit_m;
  // A redirect makes the D instruction wrong-path, so it is flushed rather than stalled.
  assign w_stall   = !rst & w_haz & !w_pc_src;
  assign w_flush_e = w_pc_src | w_stall;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e     <= '0;
      r_m     <= '0;
      r_rw_w  <= 1'b0;
      r_res_w <= 2'b00;
      r_rd_w  <= '0;
    end else begin
      r_e     <= w_flush_e ? '0 : w_dec;
      r_m     <= {r_e.rw, r_e.res, r_e.mw, r_e.rd};
      r_rw_w  <= r_m.rw;
      r_res_w <= r_m.res;
      r_rd_w  <= r_m.rd;
    end
  end
  assign io_bus.imm_src_d    = w_imm;
  assign io_bus.illegal_d    = w_ill;
  assign io_bus.alu_src_e    = r_e.src;
  assign io_bus.alu_op_e     = r_e.op;
  assign io_bus.sel_adder_e  = r_e.sel;
  assign io_bus.pc_src_e     = w_pc_src;
  assign io_bus.mem_write_m  = r_m.mw;
  assign io_bus.reg_write_w  = r_rw_w;
  assign io_bus.result_src_w = r_res_w;
  assign io_bus.rd_e         = r_e.rd;
  assign io_bus.rd_m         = r_m.rd;
  assign io_bus.rd_w         = r_rd_w;
  assign io_bus.stall_f      = w_stall;
  assign io_bus.stall_d      = w_stall;
  assign io_bus.flush_d      = w_pc_src;
  assign io_bus.flush_e      = w_flush_e;
  // M has priority over W; x0 is never forwarded.
  assign io_bus.fwd_a_e = !FWD_EN ? 2'b00 : (r_m.rd != '0 && r_m.rd == r_e.rs1) ? 2'b10 :
                          (r_rd_w != '0 && r_rd_w == r_e.rs1) ? 2'b01 : 2'b00;
  assign io_bus.fwd_b_e = !FWD_EN ? 2'b00 : (r_m.rd != '0 && r_m.rd == r_e.rs2) ? 2'b10 :
                          (r_rd_w != '0 && r_rd_w == r_e.rs2) ? 2'b01 : 2'b00;
endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// tb_rv_pipe_ctrl: table-driven bench for rv_pipe_ctrl with a W/M/E scoreboard queue.
module tb_rv_pipe_ctrl;
  localparam int RT = 'h33, IT = 'h13, LW = 'h03, SW = 'h23, BR = 'h63, JAL = 'h6F, JALR = 'h67, LUI = 'h37, BAD = 'h7F;
  typedef struct { int op, f3, rs1, rs2, rd, flg, pc, st, fe, fa, fb, ill, imm; } vec_t;
  typedef struct { logic rw; logic [1:0] res; logic mw; logic [4:0] rd; logic src; logic [1:0] aop; logic sel; } sb_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];
  sb_t  q[$];
  always #5 clk = ~clk;
  rv_pipe_ctrl_if #(.REG_ADDR_W(5)) bus ();
  rv_pipe_ctrl_if #(.REG_ADDR_W(5)) bus0 ();
  rv_pipe_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b1)) dut  (.clk(clk), .rst(rst), .io_bus(bus));
  rv_pipe_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .io_bus(bus0));
  function automatic vec_t mk(int op, int f3, int rs1, int rs2, int rd, int flg, int pc, int st, int fe,
                              int fa, int fb, int ill, int imm);
    return '{op, f3, rs1, rs2, rd, flg, pc, st, fe, fa, fb, ill, imm};
  endfunction
  // Expected E/M/W control for an instruction entering E (kill = bubbled by flush_e).
  function automatic sb_t model(int op, int rd, bit kill);
    sb_t s = '{rw: 1'b0, res: 2'b00, mw: 1'b0, rd: 5'd0, src: 1'b0, aop: 2'b00, sel: 1'b0};
    if (!kill)
      case (op)
        RT:   begin s.rw = 1'b1; s.aop = 2'b10; end
        IT:   begin s.rw = 1'b1; s.src = 1'b1; s.aop = 2'b10; end
        LW:   begin s.rw = 1'b1; s.res = 2'b01; s.src = 1'b1; end
        SW:   begin s.mw = 1'b1; s.src = 1'b1; end
        BR:   s.aop = 2'b01;
        JAL:  begin s.rw = 1'b1; s.res = 2'b10; end
        JALR: begin s.rw = 1'b1; s.res = 2'b10; s.src = 1'b1; s.sel = 1'b1; end
        LUI:  begin s.rw = 1'b1; s.src = 1'b1; s.aop = 2'b11; end
        default: ;
      endcase
    s.rd = s.rw ? 5'(rd) : 5'd0;
    return s;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    bus.op_d = 7'(v.op);
    bus.funct3_d = 3'(v.f3);
    bus.rs1_d = 5'(v.rs1);
    bus.rs2_d = 5'(v.rs2);
    bus.rd_d = 5'(v.rd);
    {bus.zero_e, bus.lt_e, bus.ltu_e} = 3'(v.flg);
  endtask
  task automatic drive0(input int op, input int rs1, input int rs2, input int rd);
    bus0.op_d = 7'(op);
    bus0.funct3_d = 3'd0;
    bus0.rs1_d = 5'(rs1);
    bus0.rs2_d = 5'(rs2);
    bus0.rd_d = 5'(rd);
    {bus0.zero_e, bus0.lt_e, bus0.ltu_e} = 3'b000;
  endtask
  initial begin
    // fields: op f3 rs1 rs2 rd {zero,lt,ltu} | pc_src stall flush_e fwd_a fwd_b illegal imm_src
    tbl.push_back(mk(RT, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(RT, 0, 1, 2, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(RT, 0, 5, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(IT, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0));
    tbl.push_back(mk(RT, 0, 1, 2, 9, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(IT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(RT, 0, 9, 9, 10, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(IT, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(RT, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(RT, 0, 0, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(IT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(LW, 2, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(RT, 0, 7, 1, 8, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(RT, 0, 7, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(IT, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(BR, 0, 1, 2, 5, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(RT, 0, 1, 2, 12, 4, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(BR, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(IT, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(BR, 6, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(IT, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(BR, 5, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(IT, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(BR, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(IT, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(LW, 2, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(JAL, 0, 7, 7, 1, 0, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(RT, 0, 7, 7, 8, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(JALR, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(IT, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(BAD, 0, 1, 2, 4, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(SW, 2, 1, 4, 3, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(LUI, 0, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0, 3));
    repeat (3) tbl.push_back(mk(IT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(LW, 2, 1, 0, 14, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(SW, 2, 1, 14, 0, 0, 0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(SW, 2, 1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(IT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(LW, 2, 1, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(LUI, 0, 15, 15, 16, 0, 0, 0, 0, 0, 0, 0, 3));
    repeat (3) tbl.push_back(mk(IT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(IT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive0(IT, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) q.push_back(model(IT, 0, 1'b1));
    foreach (tbl[i]) begin
      vec_t  v;
      string n;
      v = tbl[i];
      n = $sformatf("c%0d", i);
      drive(v);
      @(negedge clk);
      chk({n, " pc_src_e"}, 32'(bus.pc_src_e), 32'(v.pc));
      chk({n, " flush_d"}, 32'(bus.flush_d), 32'(v.pc));
      chk({n, " flush_e"}, 32'(bus.flush_e), 32'(v.fe));
      chk({n, " stall_f"}, 32'(bus.stall_f), 32'(v.st));
      chk({n, " stall_d"}, 32'(bus.stall_d), 32'(v.st));
      chk({n, " fwd_a_e"}, 32'(bus.fwd_a_e), 32'(v.fa));
      chk({n, " fwd_b_e"}, 32'(bus.fwd_b_e), 32'(v.fb));
      chk({n, " illegal_d"}, 32'(bus.illegal_d), 32'(v.ill));
      chk({n, " imm_src_d"}, 32'(bus.imm_src_d), 32'(v.imm));
      chk({n, " reg_write_w"}, 32'(bus.reg_write_w), 32'(q[0].rw));
      chk({n, " result_src_w"}, 32'(bus.result_src_w), 32'(q[0].res));
      chk({n, " rd_w"}, 32'(bus.rd_w), 32'(q[0].rd));
      chk({n, " mem_write_m"}, 32'(bus.mem_write_m), 32'(q[1].mw));
      chk({n, " rd_m"}, 32'(bus.rd_m), 32'(q[1].rd));
      chk({n, " rd_e"}, 32'(bus.rd_e), 32'(q[2].rd));
      chk({n, " alu_src_e"}, 32'(bus.alu_src_e), 32'(q[2].src));
      chk({n, " alu_op_e"}, 32'(bus.alu_op_e), 32'(q[2].aop));
      chk({n, " sel_adder_e"}, 32'(bus.sel_adder_e), 32'(q[2].sel));
      void'(q.pop_front());
      q.push_back(model(v.op, v.rd, v.fe != 0));
      @(posedge clk);
      #1;
    end
    // Reset with a jump sitting in E: no redirect/flush in the reset cycle, bubbles afterwards.
    drive(mk(JAL, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 rst = 1'b1;
    drive(mk(IT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("rst pc_src_e", 32'(bus.pc_src_e), 32'd0);
    chk("rst flush_d", 32'(bus.flush_d), 32'd0);
    chk("rst flush_e", 32'(bus.flush_e), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post-rst reg_write_w", 32'(bus.reg_write_w), 32'd0);
    chk("post-rst alu_src_e", 32'(bus.alu_src_e), 32'd0);
    chk("post-rst rd_w", 32'(bus.rd_w), 32'd0);
    // No-bypass build: a RAW dependence stalls D for two cycles.
    @(posedge clk);
    #1 drive0(RT, 1, 2, 5);
    @(posedge clk);
    #1 drive0(RT, 5, 5, 6);
    @(negedge clk);
    chk("nofwd s1 stall_f", 32'(bus0.stall_f), 32'd1);
    chk("nofwd s1 stall_d", 32'(bus0.stall_d), 32'd1);
    chk("nofwd s1 flush_e", 32'(bus0.flush_e), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("nofwd s2 stall_d", 32'(bus0.stall_d), 32'd1);
    chk("nofwd s2 flush_e", 32'(bus0.flush_e), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("nofwd s3 stall_d", 32'(bus0.stall_d), 32'd0);
    chk("nofwd s3 reg_write_w", 32'(bus0.reg_write_w), 32'd1);
    chk("nofwd s3 rd_w", 32'(bus0.rd_w), 32'd5);
    @(posedge clk);
    #1 drive0(IT, 0, 0, 0);
    @(negedge clk);
    chk("nofwd rd_e", 32'(bus0.rd_e), 32'd6);
    chk("nofwd fwd_a_e", 32'(bus0.fwd_a_e), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
